// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for a single FIFO: round-robin among NUM_REQ requesters,
// with an optional locked burst of up to MAX_BURST consecutive writes for one
// owner. Grants are combinational from registered state and are accepted at
// the same rising edge (zero-cycle accept latency); no data is buffered here.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_n,
    input  logic [NUM_REQ-1:0]       i_Req,
    input  logic [NUM_REQ-1:0]       i_Lock,
    input  logic [NUM_REQ*WIDTH-1:0] i_Data,
    output logic [NUM_REQ-1:0]       o_Gnt,
    output logic                     o_WrEn,
    output logic [WIDTH-1:0]         o_WrData,
    input  logic                     i_Full,
    output logic [NUM_REQ-1:0]       o_Owner
);

    localparam int              IDXW     = $clog2(NUM_REQ);
    localparam int              CNTW     = $clog2(MAX_BURST + 1);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(MAX_BURST);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    // In BURST the owner is always the last IDLE winner, so r_Last doubles
    // as the owner index and no separate owner register is kept.
    state_t          r_State;
    state_t          w_NextState;
    logic [IDXW-1:0] r_Last;
    logic [IDXW-1:0] w_NextLast;
    logic [CNTW-1:0] r_Count;
    logic [CNTW-1:0] w_NextCount;
    logic [CNTW-1:0] w_CountInc;
    logic            w_RrFound;
    logic [IDXW-1:0] w_RrIdx;
    logic            w_Grant;
    logic [IDXW-1:0] w_GntIdx;
    logic            w_CanWrite;

    function automatic logic [IDXW-1:0] f_Wrap(input logic [IDXW-1:0] base,
                                               input int unsigned     off);
        return IDXW'((int'(base) + int'(off)) % NUM_REQ);
    endfunction

    // Writes are blocked by a full FIFO and, asynchronously, by reset.
    assign w_CanWrite = i_Rst_n & ~i_Full;
    assign w_CountInc = r_Count + 1'b1;

    // Round-robin search starting one past the last winner, with wrap-around.
    always_comb begin
        w_RrFound = 1'b0;
        w_RrIdx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!w_RrFound && i_Req[f_Wrap(r_Last, i)]) begin
                w_RrFound = 1'b1;
                w_RrIdx   = f_Wrap(r_Last, i);
            end
        end
    end

    // Next-state, pointer and burst-count logic plus grant decision.
    always_comb begin
        w_NextState = r_State;
        w_NextLast  = r_Last;
        w_NextCount = r_Count;
        w_Grant     = 1'b0;
        w_GntIdx    = r_Last;
        case (r_State)
            IDLE: begin
                if (w_RrFound && w_CanWrite) begin
                    w_Grant    = 1'b1;
                    w_GntIdx   = w_RrIdx;
                    w_NextLast = w_RrIdx;
                    if (i_Lock[w_RrIdx] && (MAX_BURST > 1)) begin
                        w_NextState = BURST;
                        w_NextCount = CNTW'(1);
                    end
                end
            end
            BURST: begin
                if (i_Req[r_Last] && w_CanWrite) begin
                    w_Grant = 1'b1;
                end
                // A dropped lock or request ends the burst even while full;
                // the final write still goes through when possible.
                if (!i_Req[r_Last] || !i_Lock[r_Last]) begin
                    w_NextState = IDLE;
                    w_NextCount = '0;
                end else if (w_Grant) begin
                    if (w_CountInc == CNT_MAX) begin
                        w_NextState = IDLE;
                        w_NextCount = '0;
                    end else begin
                        w_NextCount = w_CountInc;
                    end
                end
            end
            default: begin
                w_NextState = IDLE;
                w_NextCount = '0;
            end
        endcase
    end

    // Grant strobe, FIFO write port and owner indication.
    always_comb begin
        o_Gnt    = '0;
        o_WrEn   = w_Grant;
        o_WrData = '0;
        o_Owner  = '0;
        if (w_Grant) begin
            o_Gnt[w_GntIdx] = 1'b1;
            o_WrData        = i_Data[w_GntIdx*WIDTH +: WIDTH];
        end
        if (r_State == BURST) begin
            o_Owner[r_Last] = 1'b1;
        end
    end

    // State registers; reset gives requester 0 first priority.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State <= IDLE;
            r_Last  <= LAST_RST;
            r_Count <= '0;
        end else begin
            r_State <= w_NextState;
            r_Last  <= w_NextLast;
            r_Count <= w_NextCount;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by a
// randomized phase, all checked against a behavioural arbitration model and a
// queue-based FIFO that drives i_Full.
module tb_fifo_wr_arbiter;

    localparam int W     = 8;
    localparam int N     = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic           wren;
    logic [W-1:0]   wrdata;
    logic           full;
    logic [N-1:0]   owner;

    int checks = 0;
    int errors = 0;
    int nwrites = 0;

    // Reference model state: burst flag, last winner, writes in current burst.
    bit m_burst;
    int m_last;
    int m_cnt;

    logic [W-1:0] fifo[$];
    logic [W-1:0] rdlog[$];
    bit drain;
    bit force_full;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .WIDTH     (W),
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .i_Clk    (clk),
        .i_Rst_n  (rst_n),
        .i_Req    (req),
        .i_Lock   (lock),
        .i_Data   (data),
        .o_Gnt    (gnt),
        .o_WrEn   (wren),
        .o_WrData (wrdata),
        .i_Full   (full),
        .o_Owner  (owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_burst = 1'b0;
        m_last  = N - 1;
        m_cnt   = 0;
    endtask

    // One clock cycle: entered just after a falling edge with inputs set.
    task automatic cycle();
        int           e;
        int           own;
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        logic [N-1:0] eo;
        bit           w;
        logic [W-1:0] d;
        full = force_full || (fifo.size() >= DEPTH);
        #1;
        e = -1;
        if (!m_burst) begin
            if (!full) begin
                for (int k = 1; k <= N; k++) begin
                    if (e < 0 && req[(m_last + k) % N]) e = (m_last + k) % N;
                end
            end
        end else if (req[m_last] && !full) begin
            e = m_last;
        end
        eg = (e >= 0) ? (N'(1) << e) : '0;
        ed = (e >= 0) ? data[e*W +: W] : '0;
        eo = m_burst ? (N'(1) << m_last) : '0;
        chk("gnt", gnt, eg);
        chk("wren", wren, e >= 0);
        chk("wrdata", wrdata, ed);
        chk("owner", owner, eo);
        chk("overflow", wren & full, 0);
        w = wren;
        d = wrdata;
        @(posedge clk);
        if (drain && fifo.size() > 0) rdlog.push_back(fifo.pop_front());
        if (w) begin
            fifo.push_back(d);
            nwrites++;
        end
        own = m_last;
        if (!m_burst) begin
            if (e >= 0) begin
                m_last = e;
                if (lock[e] && MB > 1) begin
                    m_burst = 1'b1;
                    m_cnt   = 1;
                end
            end
        end else if (!req[own] || !lock[own]) begin
            m_burst = 1'b0;
            m_cnt   = 0;
        end else if (e >= 0) begin
            m_cnt++;
            if (m_cnt == MB) begin
                m_burst = 1'b0;
                m_cnt   = 0;
            end
        end
        @(negedge clk);
    endtask

    // Reset pulse spanning one rising edge; outputs must be idle while low.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_wren", wren, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_owner", owner, 0);
        model_reset();
        fifo.delete();
        force_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '1;
        lock       = '0;
        data       = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        drain      = 1'b0;
        force_full = 1'b0;
        full       = 1'b0;
        model_reset();
        #2;
        chk("por_gnt", gnt, 0);
        chk("por_wren", wren, 0);
        chk("por_wrdata", wrdata, 0);
        chk("por_owner", owner, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All four request without lock: fill in round-robin order, then drain.
        repeat (6) cycle();
        chk("fill_level", fifo.size(), DEPTH);
        req   = '0;
        drain = 1'b1;
        repeat (5) cycle();
        chk("drain_count", rdlog.size(), 4);
        for (int k = 0; k < 4; k++) chk("drain_order", rdlog[k], 8'hA0 + k);

        // Two requesters alternate while the FIFO drains every cycle.
        req = 4'b0101;
        repeat (8) cycle();

        // Locked requester 1 capped at MAX_BURST, requester 3 gets a turn.
        do_reset();
        req  = 4'b1010;
        lock = 4'b0010;
        repeat (10) cycle();

        // Owner drops lock after two writes: third write still granted.
        do_reset();
        req  = 4'b1010;
        lock = 4'b0010;
        cycle();
        cycle();
        lock = 4'b0000;
        cycle();
        chk("lock_drop_owner", owner, 0);
        cycle();
        cycle();

        // FIFO full for three cycles mid-burst: count holds, four writes total.
        do_reset();
        req  = 4'b0010;
        lock = 4'b0010;
        nwrites = 0;
        cycle();
        force_full = 1'b1;
        repeat (3) cycle();
        force_full = 1'b0;
        repeat (3) cycle();
        chk("full_burst_writes", nwrites, 4);
        chk("full_burst_done_owner", owner, 0);
        repeat (2) cycle();

        // Reset pulse mid-burst, then requester 3 alone after release.
        do_reset();
        req  = 4'b0010;
        lock = 4'b0010;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wren", wren, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_owner", owner, 0);
        model_reset();
        fifo.delete();
        @(negedge clk);
        req   = 4'b1000;
        lock  = 4'b0000;
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt", gnt, 4'b1000);
        @(negedge clk);
        model_reset();
        fifo.delete();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Randomized traffic with lock bias, backpressure and rare resets.
        repeat (400) begin
            req        = N'($urandom);
            lock       = N'($urandom | $urandom);
            data       = $urandom;
            drain      = ($urandom % 4) != 0;
            force_full = ($urandom % 6) == 0;
            if (($urandom % 80) == 0) do_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
